// File: rtl/machine_mode_types_1_11_pkg.sv
// Shared machine-mode trap types: exception codes, tval source select,
// interrupt-bit position helper. Optional build macro: PRV_TVAL_INSN_EN.
package machine_mode_types_1_11_pkg;

  localparam int unsigned CODE_W       = 8;
  localparam int unsigned INTR_CAUSE_W = 5;

  typedef enum logic [4:0] {
    EX_MAL_INSN     = 5'd0,
    EX_FAULT_INSN   = 5'd1,
    EX_ILLEGAL_INSN = 5'd2,
    EX_BREAKPOINT   = 5'd3,
    EX_MAL_L        = 5'd4,
    EX_FAULT_L      = 5'd5,
    EX_MAL_S        = 5'd6,
    EX_FAULT_S      = 5'd7,
    EX_ENV_M        = 5'd11
  } ex_code_t;

  typedef enum logic [1:0] {
    TVAL_ZERO = 2'd0,
    TVAL_ADDR = 2'd1,
    TVAL_INSN = 2'd2
  } tval_sel_e;

  // mcause interrupt flag sits in the MSB of the XLEN-wide register
  function automatic int unsigned intr_bit_pos(input int unsigned xlen);
    return xlen - 1;
  endfunction

endpackage

// File: rtl/prv_trap_sequencer_if.sv
// Trap sequencer bus: event/CSR inputs from the pipeline, commit/redirect outputs.
interface prv_trap_sequencer_if #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned NUM_EXTENSIONS = 4
);
  logic                      fault_insn;
  logic                      mal_insn;
  logic                      illegal_insn;
  logic                      fault_l;
  logic                      mal_l;
  logic                      fault_s;
  logic                      mal_s;
  logic                      breakpoint;
  logic                      env_m;
  logic [NUM_EXTENSIONS-1:0] ex_rmgmt;
  logic                      ret;
  logic                      intr;
  logic [4:0]                intr_cause;
  logic [XLEN-1:0]           epc;
  logic [XLEN-1:0]           badaddr;
  logic [XLEN-1:0]           insn_bits;
  logic [XLEN-1:0]           mtvec;
  logic [XLEN-1:0]           mepc_rd;
  logic                      pipe_clear;
  logic                      insert_ack;
  logic                      busy;
  logic                      csr_commit;
  logic                      is_ret;
  logic [XLEN-1:0]           mcause;
  logic [XLEN-1:0]           mepc_wr;
  logic [XLEN-1:0]           mtval_wr;
  logic                      insert_pc;
  logic [XLEN-1:0]           priv_pc;

  modport master (
    output fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s,
           breakpoint, env_m, ex_rmgmt, ret, intr, intr_cause, epc, badaddr,
           insn_bits, mtvec, mepc_rd, pipe_clear, insert_ack,
    input  busy, csr_commit, is_ret, mcause, mepc_wr, mtval_wr, insert_pc, priv_pc
  );

  modport slave (
    input  fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s,
           breakpoint, env_m, ex_rmgmt, ret, intr, intr_cause, epc, badaddr,
           insn_bits, mtvec, mepc_rd, pipe_clear, insert_ack,
    output busy, csr_commit, is_ret, mcause, mepc_wr, mtval_wr, insert_pc, priv_pc
  );
endinterface

// File: rtl/prv_cause_encoder.sv
// Combinational trap priority encoder: interrupt > sync exceptions >
// lowest extension request > mret. Uses PRV_TVAL_INSN_EN for illegal-insn tval.
module prv_cause_encoder
  import machine_mode_types_1_11_pkg::*;
#(
  parameter int unsigned NUM_EXTENSIONS   = 4,
  parameter int unsigned RMGMT_CAUSE_BASE = 24
) (
  input  logic                      intr,
  input  logic                      fault_insn,
  input  logic                      mal_insn,
  input  logic                      illegal_insn,
  input  logic                      fault_l,
  input  logic                      mal_l,
  input  logic                      fault_s,
  input  logic                      mal_s,
  input  logic                      breakpoint,
  input  logic                      env_m,
  input  logic [NUM_EXTENSIONS-1:0] ex_rmgmt,
  input  logic                      ret,
  output logic                      valid_c,
  output logic                      is_intr_c,
  output logic                      is_ret_c,
  output logic [CODE_W-1:0]         code_c,
  output tval_sel_e                 tval_sel_c
);

  logic [CODE_W-1:0] rmgmt_code_c;

  // Lowest set extension line wins: scan downwards so the last hit is the lowest
  always_comb begin
    rmgmt_code_c = '0;
    for (int i = int'(NUM_EXTENSIONS) - 1; i >= 0; i--) begin
      if (ex_rmgmt[i]) begin
        rmgmt_code_c = CODE_W'(RMGMT_CAUSE_BASE + 32'(i));
      end
    end
  end

  // Fixed priority chain across all trap sources
  always_comb begin
    valid_c    = 1'b1;
    is_intr_c  = 1'b0;
    is_ret_c   = 1'b0;
    code_c     = '0;
    tval_sel_c = TVAL_ZERO;
    if (intr) begin
      is_intr_c = 1'b1;
    end else if (fault_insn) begin
      code_c     = CODE_W'(EX_FAULT_INSN);
      tval_sel_c = TVAL_ADDR;
    end else if (mal_insn) begin
      code_c     = CODE_W'(EX_MAL_INSN);
      tval_sel_c = TVAL_ADDR;
    end else if (illegal_insn) begin
      code_c     = CODE_W'(EX_ILLEGAL_INSN);
`ifdef PRV_TVAL_INSN_EN
      tval_sel_c = TVAL_INSN;
`else
      tval_sel_c = TVAL_ZERO;
`endif
    end else if (breakpoint) begin
      code_c = CODE_W'(EX_BREAKPOINT);
    end else if (env_m) begin
      code_c = CODE_W'(EX_ENV_M);
    end else if (mal_l) begin
      code_c     = CODE_W'(EX_MAL_L);
      tval_sel_c = TVAL_ADDR;
    end else if (mal_s) begin
      code_c     = CODE_W'(EX_MAL_S);
      tval_sel_c = TVAL_ADDR;
    end else if (fault_l) begin
      code_c     = CODE_W'(EX_FAULT_L);
      tval_sel_c = TVAL_ADDR;
    end else if (fault_s) begin
      code_c     = CODE_W'(EX_FAULT_S);
      tval_sel_c = TVAL_ADDR;
    end else if (|ex_rmgmt) begin
      code_c = rmgmt_code_c;
    end else if (ret) begin
      is_ret_c = 1'b1;
    end else begin
      valid_c = 1'b0;
    end
  end

endmodule

// File: rtl/prv_trap_sequencer.sv
// Multi-cycle trap/mret sequencer: capture, wait for pipeline flush, one-cycle
// CSR commit, then hold the redirect until fetch acks. Optional macro: PRV_TVAL_INSN_EN.
module prv_trap_sequencer
  import machine_mode_types_1_11_pkg::*;
#(
  parameter int unsigned NUM_EXTENSIONS   = 4,
  parameter int unsigned RMGMT_CAUSE_BASE = 24,
  parameter int unsigned XLEN             = 32
) (
  input logic           CLK,
  input logic           nRST,
  prv_trap_sequencer_if.slave bus
);

  localparam int unsigned INTR_BIT = intr_bit_pos(XLEN);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_CLEAR = 2'd1,
    S_COMMIT     = 2'd2,
    S_INSERT     = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              csr_commit_q, csr_commit_d;
  logic              is_ret_q, is_ret_d;
  logic              insert_pc_q, insert_pc_d;
  logic              cap_ret_q, cap_ret_d;
  logic [XLEN-1:0]   mcause_q, mcause_d;
  logic [XLEN-1:0]   mepc_wr_q, mepc_wr_d;
  logic [XLEN-1:0]   mtval_wr_q, mtval_wr_d;
  logic [XLEN-1:0]   priv_pc_q, priv_pc_d;

  logic              enc_valid_c;
  logic              enc_is_intr_c;
  logic              enc_is_ret_c;
  logic [CODE_W-1:0] enc_code_c;
  tval_sel_e         enc_tval_sel_c;
  logic [XLEN-1:0]   tvec_base_c;
  logic [XLEN-1:0]   tval_c;

  prv_cause_encoder #(
    .NUM_EXTENSIONS   (NUM_EXTENSIONS),
    .RMGMT_CAUSE_BASE (RMGMT_CAUSE_BASE)
  ) u_cause_encoder (
    .intr         (bus.intr),
    .fault_insn   (bus.fault_insn),
    .mal_insn     (bus.mal_insn),
    .illegal_insn (bus.illegal_insn),
    .fault_l      (bus.fault_l),
    .mal_l        (bus.mal_l),
    .fault_s      (bus.fault_s),
    .mal_s        (bus.mal_s),
    .breakpoint   (bus.breakpoint),
    .env_m        (bus.env_m),
    .ex_rmgmt     (bus.ex_rmgmt),
    .ret          (bus.ret),
    .valid_c      (enc_valid_c),
    .is_intr_c    (enc_is_intr_c),
    .is_ret_c     (enc_is_ret_c),
    .code_c       (enc_code_c),
    .tval_sel_c   (enc_tval_sel_c)
  );

  // Low mepc bits are always cleared on return; insn_bits only feeds tval under the option
`ifdef PRV_TVAL_INSN_EN
  logic unused_c;
  assign unused_c = ^bus.mepc_rd[1:0];
`else
  logic unused_c;
  assign unused_c = ^{bus.mepc_rd[1:0], bus.insn_bits};
`endif

  assign tvec_base_c = {bus.mtvec[XLEN-1:2], 2'b00};

  // Trap value source for the captured exception
  always_comb begin
    tval_c = '0;
    unique case (enc_tval_sel_c)
      TVAL_ADDR: tval_c = bus.badaddr;
`ifdef PRV_TVAL_INSN_EN
      TVAL_INSN: tval_c = bus.insn_bits;
`endif
      default:   tval_c = '0;
    endcase
  end

  // Next-state, capture and registered-output logic
  always_comb begin
    state_d    = state_q;
    cap_ret_d  = cap_ret_q;
    mcause_d   = mcause_q;
    mepc_wr_d  = mepc_wr_q;
    mtval_wr_d = mtval_wr_q;
    priv_pc_d  = priv_pc_q;

    unique case (state_q)
      S_IDLE: begin
        if (enc_valid_c) begin
          state_d   = S_WAIT_CLEAR;
          cap_ret_d = enc_is_ret_c;
          if (enc_is_ret_c) begin
            // mret only redirects; trap CSRs keep their last capture
            priv_pc_d = {bus.mepc_rd[XLEN-1:2], 2'b00};
          end else if (enc_is_intr_c) begin
            mcause_d                     = '0;
            mcause_d[INTR_BIT]           = 1'b1;
            mcause_d[INTR_CAUSE_W-1:0]   = bus.intr_cause;
            mepc_wr_d                    = bus.epc;
            mtval_wr_d                   = '0;
            priv_pc_d                    = tvec_base_c;
            if (bus.mtvec[1:0] == 2'b01) begin
              priv_pc_d = tvec_base_c + XLEN'({bus.intr_cause, 2'b00});
            end
          end else begin
            mcause_d   = XLEN'(enc_code_c);
            mepc_wr_d  = bus.epc;
            mtval_wr_d = tval_c;
            priv_pc_d  = tvec_base_c;
          end
        end
      end
      S_WAIT_CLEAR: begin
        if (bus.pipe_clear) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        state_d = S_INSERT;
      end
      S_INSERT: begin
        if (bus.insert_ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d       = (state_d != S_IDLE);
    csr_commit_d = (state_d == S_COMMIT);
    is_ret_d     = csr_commit_d && cap_ret_d;
    insert_pc_d  = (state_d == S_INSERT);
  end

  // State and output registers; reset aborts any sequence in flight
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      csr_commit_q <= 1'b0;
      is_ret_q     <= 1'b0;
      insert_pc_q  <= 1'b0;
      cap_ret_q    <= 1'b0;
      mcause_q     <= '0;
      mepc_wr_q    <= '0;
      mtval_wr_q   <= '0;
      priv_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      csr_commit_q <= csr_commit_d;
      is_ret_q     <= is_ret_d;
      insert_pc_q  <= insert_pc_d;
      cap_ret_q    <= cap_ret_d;
      mcause_q     <= mcause_d;
      mepc_wr_q    <= mepc_wr_d;
      mtval_wr_q   <= mtval_wr_d;
      priv_pc_q    <= priv_pc_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.csr_commit = csr_commit_q;
  assign bus.is_ret     = is_ret_q;
  assign bus.mcause     = mcause_q;
  assign bus.mepc_wr    = mepc_wr_q;
  assign bus.mtval_wr   = mtval_wr_q;
  assign bus.insert_pc  = insert_pc_q;
  assign bus.priv_pc    = priv_pc_q;

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// Randomised self-checking bench for prv_trap_sequencer against a
// transaction-level reference model (priority table + expected timeline).
module tb_prv_trap_sequencer;

  logic CLK;
  logic nRST;
  int   n_checks;
  int   n_pass;

  prv_trap_sequencer_if #(.XLEN(32), .NUM_EXTENSIONS(4)) bus ();

  prv_trap_sequencer #(
    .NUM_EXTENSIONS   (4),
    .RMGMT_CAUSE_BASE (24),
    .XLEN             (32)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        intr;
    logic [4:0]  intr_cause;
    logic        fault_insn;
    logic        mal_insn;
    logic        illegal_insn;
    logic        fault_l;
    logic        mal_l;
    logic        fault_s;
    logic        mal_s;
    logic        breakpoint;
    logic        env_m;
    logic [3:0]  rmgmt;
    logic        ret;
    logic [31:0] epc;
    logic [31:0] badaddr;
    logic [31:0] insn;
    logic [31:0] mtvec;
    logic [31:0] mepc_rd;
  } ev_t;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic drive_ev(input ev_t e);
    bus.intr         = e.intr;
    bus.intr_cause   = e.intr_cause;
    bus.fault_insn   = e.fault_insn;
    bus.mal_insn     = e.mal_insn;
    bus.illegal_insn = e.illegal_insn;
    bus.fault_l      = e.fault_l;
    bus.mal_l        = e.mal_l;
    bus.fault_s      = e.fault_s;
    bus.mal_s        = e.mal_s;
    bus.breakpoint   = e.breakpoint;
    bus.env_m        = e.env_m;
    bus.ex_rmgmt     = e.rmgmt;
    bus.ret          = e.ret;
    bus.epc          = e.epc;
    bus.badaddr      = e.badaddr;
    bus.insn_bits    = e.insn;
    bus.mtvec        = e.mtvec;
    bus.mepc_rd      = e.mepc_rd;
  endtask

  function automatic ev_t rand_ev(input int den);
    ev_t e;
    e              = '0;
    e.intr         = ($urandom_range(den - 1) == 0);
    e.intr_cause   = 5'($urandom);
    e.fault_insn   = ($urandom_range(den - 1) == 0);
    e.mal_insn     = ($urandom_range(den - 1) == 0);
    e.illegal_insn = ($urandom_range(den - 1) == 0);
    e.fault_l      = ($urandom_range(den - 1) == 0);
    e.mal_l        = ($urandom_range(den - 1) == 0);
    e.fault_s      = ($urandom_range(den - 1) == 0);
    e.mal_s        = ($urandom_range(den - 1) == 0);
    e.breakpoint   = ($urandom_range(den - 1) == 0);
    e.env_m        = ($urandom_range(den - 1) == 0);
    e.rmgmt        = ($urandom_range(den - 1) == 0) ? 4'($urandom) : 4'b0;
    e.ret          = ($urandom_range(2) == 0);
    e.epc          = $urandom;
    e.badaddr      = $urandom;
    e.insn         = $urandom;
    e.mtvec        = $urandom;
    e.mepc_rd      = $urandom;
    return e;
  endfunction

  function automatic logic has_event(input ev_t e);
    return e.intr | e.fault_insn | e.mal_insn | e.illegal_insn | e.fault_l | e.mal_l |
           e.fault_s | e.mal_s | e.breakpoint | e.env_m | (|e.rmgmt) | e.ret;
  endfunction

  // Reference model: which trap wins and what the CSRs and redirect become
  function automatic void model(input ev_t e, output logic is_r, output logic [31:0] mc,
                                output logic [31:0] tv, output logic [31:0] pc);
    logic        fl [9];
    int          codes [9];
    logic [31:0] base;
    int          code;
    logic        found;
    fl    = '{e.fault_insn, e.mal_insn, e.illegal_insn, e.breakpoint, e.env_m,
              e.mal_l, e.mal_s, e.fault_l, e.fault_s};
    codes = '{1, 0, 2, 3, 11, 4, 6, 5, 7};
    base  = e.mtvec & 32'hFFFF_FFFC;
    is_r  = 1'b0;
    mc    = 32'h0;
    tv    = 32'h0;
    pc    = base;
    found = 1'b0;
    code  = 0;
    if (e.intr) begin
      mc = 32'h8000_0000 + 32'(e.intr_cause);
      if (e.mtvec[1:0] == 2'b01) pc = base + 32'(e.intr_cause) * 4;
      return;
    end
    for (int i = 0; i < 9; i++) begin
      if (!found && fl[i]) begin
        found = 1'b1;
        code  = codes[i];
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (!found && e.rmgmt[i]) begin
        found = 1'b1;
        code  = 24 + i;
      end
    end
    if (!found) begin
      is_r = 1'b1;
      pc   = e.mepc_rd & 32'hFFFF_FFFC;
      return;
    end
    mc = 32'(code);
    if (code inside {0, 1, 4, 5, 6, 7}) tv = e.badaddr;
`ifdef PRV_TVAL_INSN_EN
    if (code == 2) tv = e.insn;
`endif
  endfunction

  // One trap: event, d extra WAIT_CLEAR cycles, a cycles of withheld ack.
  // Entered and left at a negedge with the sequencer idle.
  task automatic run_trap(input ev_t e, input int d, input int a);
    logic        exp_r;
    logic [31:0] exp_mc, exp_tv, exp_pc;
    int          total;
    model(e, exp_r, exp_mc, exp_tv, exp_pc);
    total = d + 3 + a;
    drive_ev(e);
    bus.pipe_clear = 1'($urandom_range(1));
    bus.insert_ack = 1'($urandom_range(1));
    for (int k = 0; k <= total; k++) begin
      @(negedge CLK);
      check_eq("busy", 32'(bus.busy), 32'(k <= d + 2 + a));
      check_eq("csr_commit", 32'(bus.csr_commit), 32'(k == d + 1));
      check_eq("insert_pc", 32'(bus.insert_pc), 32'(k >= d + 2 && k <= d + 2 + a));
      if (k == d + 1) begin
        check_eq("is_ret", 32'(bus.is_ret), 32'(exp_r));
        if (!exp_r) begin
          check_eq("mcause", bus.mcause, exp_mc);
          check_eq("mepc_wr", bus.mepc_wr, e.epc);
          check_eq("mtval_wr", bus.mtval_wr, exp_tv);
        end
      end else begin
        check_eq("is_ret_idle", 32'(bus.is_ret), 32'h0);
      end
      if (k >= d + 2 && k <= d + 2 + a) check_eq("priv_pc", bus.priv_pc, exp_pc);
      if (k < total) begin
        drive_ev(rand_ev(3));
        if (k < d) bus.pipe_clear = 1'b0;
        else if (k == d) bus.pipe_clear = 1'b1;
        else bus.pipe_clear = 1'($urandom_range(1));
        if (k < d + 2) bus.insert_ack = 1'($urandom_range(1));
        else bus.insert_ack = (k == d + 2 + a);
      end else begin
        drive_ev('0);
        bus.pipe_clear = 1'b0;
        bus.insert_ack = 1'b0;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'h0);
    check_eq({tag, "_commit"}, 32'(bus.csr_commit), 32'h0);
    check_eq({tag, "_is_ret"}, 32'(bus.is_ret), 32'h0);
    check_eq({tag, "_mcause"}, bus.mcause, 32'h0);
    check_eq({tag, "_mepc"}, bus.mepc_wr, 32'h0);
    check_eq({tag, "_mtval"}, bus.mtval_wr, 32'h0);
    check_eq({tag, "_insert"}, 32'(bus.insert_pc), 32'h0);
    check_eq({tag, "_priv_pc"}, bus.priv_pc, 32'h0);
  endtask

  initial begin
    ev_t e;
    n_checks = 0;
    n_pass   = 0;
    nRST     = 1'b0;
    drive_ev('0);
    bus.pipe_clear = 1'b0;
    bus.insert_ack = 1'b0;
    repeat (2) @(negedge CLK);
    check_all_zero("reset");
    nRST = 1'b1;
    @(negedge CLK);

    // Illegal instruction, plain mtvec
    e = '0; e.illegal_insn = 1'b1; e.epc = 32'h100; e.mtvec = 32'h8000_0000;
    e.badaddr = 32'h1234_5678; e.insn = 32'hFFFF_FFFF;
    run_trap(e, 2, 0);
    // Vectored interrupt beats a load misalign
    e = '0; e.intr = 1'b1; e.intr_cause = 5'd7; e.mal_l = 1'b1; e.mtvec = 32'h8000_0001;
    e.epc = 32'h44; e.badaddr = 32'hDEAD_BEEF;
    run_trap(e, 0, 0);
    // Lowest extension line
    e = '0; e.rmgmt = 4'b1010; e.epc = 32'h200; e.mtvec = 32'h0000_1000;
    run_trap(e, 1, 1);
    // Store misalign beats store fault
    e = '0; e.fault_s = 1'b1; e.mal_s = 1'b1; e.badaddr = 32'hCAFE_0003; e.epc = 32'h300;
    e.mtvec = 32'h0000_2002;
    run_trap(e, 0, 2);
    // mret redirect
    e = '0; e.ret = 1'b1; e.mepc_rd = 32'h2003;
    run_trap(e, 0, 0);
    // mret discarded by ecall
    e = '0; e.ret = 1'b1; e.env_m = 1'b1; e.epc = 32'h400; e.mepc_rd = 32'h5000;
    e.mtvec = 32'h0000_3000;
    run_trap(e, 0, 0);
    // Long ack wait with noise on event inputs
    e = '0; e.fault_l = 1'b1; e.badaddr = 32'h0000_0ABC; e.epc = 32'h500; e.mtvec = 32'h100;
    run_trap(e, 2, 5);

    // Random traffic, sometimes back to back
    for (int n = 0; n < 150; n++) begin
      e = rand_ev(6);
      if (!has_event(e)) e.ret = 1'b1;
      run_trap(e, $urandom_range(3), $urandom_range(4));
      for (int g = $urandom_range(2); g > 0; g--) begin
        @(negedge CLK);
        check_eq("idle_busy", 32'(bus.busy), 32'h0);
      end
    end

    // Reset in the middle of WAIT_CLEAR
    e = '0; e.fault_l = 1'b1; e.badaddr = 32'h77; e.epc = 32'h600; e.mtvec = 32'h4000;
    drive_ev(e);
    @(negedge CLK);
    check_eq("pre_rst_busy", 32'(bus.busy), 32'h1);
    bus.pipe_clear = 1'b1;
    bus.insert_ack = 1'b1;
    nRST = 1'b0;
    #1;
    check_all_zero("async_rst");
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check_eq("rst_no_commit", 32'(bus.csr_commit), 32'h0);
    end
    drive_ev('0);
    bus.pipe_clear = 1'b0;
    bus.insert_ack = 1'b0;
    nRST = 1'b1;
    repeat (2) @(negedge CLK);
    check_all_zero("post_rst");

    // Illegal instruction tval after reset
    e = '0; e.illegal_insn = 1'b1; e.insn = 32'hFFFF_FFFF; e.epc = 32'h700;
    e.mtvec = 32'h8000_0000;
    run_trap(e, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prv_trap_sequencer.md
Name: prv_trap_sequencer

Overview:
- Multi-cycle trap/return sequencer inside the priv block. It replaces the single-cycle insert_pc path.
- Prioritises synchronous exceptions, interrupts, NUM_EXTENSIONS resource-management requests and mret.
- Captures cause, epc and tval, and waits for the hazard unit to confirm the pipeline is cleared.
- Issues a one-cycle CSR commit, then holds the redirect PC until fetch acknowledges it.

Parameters:
- NUM_EXTENSIONS, 4, number of ex_rmgmt request lines; must be >= 1.
- RMGMT_CAUSE_BASE, 24, mcause code for ex_rmgmt[0]; line i uses RMGMT_CAUSE_BASE+i (custom cause range).
- XLEN, 32, data and address width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s, breakpoint, env_m  in  1 each  synchronous exception flags.
- ex_rmgmt  in  NUM_EXTENSIONS  extension trap requests; several may be high at once.
- ret  in  1  mret retiring.
- intr  in  1  enabled interrupt pending (already masked by mie/mstatus).
- intr_cause  in  5  interrupt code.
- epc  in  XLEN  PC of the faulting or retiring instruction.
- badaddr  in  XLEN  faulting address.
- insn_bits  in  XLEN  instruction word (used only under the option).
- mtvec  in  XLEN  mtvec CSR; [1:0]=mode.
- mepc_rd  in  XLEN  current mepc.
- pipe_clear  in  1  hazard unit reports the pipeline is flushed.
- insert_ack  in  1  fetch accepted priv_pc.
- busy  out  1  sequencer is not IDLE; hazard unit stalls and flushes.
- csr_commit  out  1  one-cycle pulse: write the mcause/mepc/mtval outputs, or perform the mret mstatus restore.
- is_ret  out  1  qualifies csr_commit as an mret.
- mcause  out  XLEN  captured cause.
- mepc_wr  out  XLEN  captured epc.
- mtval_wr  out  XLEN  captured tval.
- insert_pc  out  1  redirect valid.
- priv_pc  out  XLEN  redirect target.

Behaviour:
- Reset: state=IDLE; all outputs 0. Asynchronous reset mid-sequence aborts to IDLE with no commit issued.
- FSM states: IDLE -> WAIT_CLEAR -> COMMIT -> INSERT -> IDLE.
- IDLE, priority on the same cycle:
  - intr
  - fault_insn(1) > mal_insn(0) > illegal_insn(2) > breakpoint(3) > env_m(11) > mal_l(4) > mal_s(6) > fault_l(5) > fault_s(7)
  - lowest-index ex_rmgmt (cause RMGMT_CAUSE_BASE+i)
  - ret
- A ret together with any exception is discarded; the exception wins.
- On any of these events, IDLE registers cause/epc/tval/target and moves to WAIT_CLEAR; busy=1 from the next cycle.
- mcause encoding:
  - interrupt: {1'b1, zeros, intr_cause}
  - exception: {1'b0, zero-extended code}
- mtval_wr:
  - badaddr for codes 0, 1, 4, 5, 6, 7
  - 0 otherwise
- priv_pc, computed at capture, mod 2^XLEN:
  - base = {mtvec[XLEN-1:2], 2'b00}
  - interrupt with mtvec[1:0]==1: base + (intr_cause << 2)
  - other traps: base
  - ret: mepc_rd with bits [1:0] cleared
- WAIT_CLEAR: hold until pipe_clear=1, then go to COMMIT. pipe_clear already high on entry is accepted on the first WAIT_CLEAR cycle.
- COMMIT: csr_commit=1 for exactly one cycle; is_ret=1 when the captured event is mret; then go to INSERT.
- INSERT: insert_pc=1 and priv_pc stable until insert_ack=1. Return to IDLE on the cycle after the ack; insert_pc=0 in IDLE.
- Best-case latency from event to insert_pc is 3 cycles.
- All event inputs are ignored outside IDLE; the pipeline is being flushed and re-raises anything lost.
- A new event seen in IDLE on the cycle after INSERT is accepted normally (back-to-back traps).
- mcause, mepc_wr and mtval_wr hold their values until the next capture.

Optional Feature:
- Macro: PRV_TVAL_INSN_EN.
- Defined: illegal_insn (code 2) captures mtval_wr=insn_bits.
- Undefined: code 2 gives mtval_wr=0, and insn_bits is unused.

Decomposition:
- machine_mode_types_1_11_pkg: exception code enum (ex_code_t, values above) and the interrupt-bit position constant.
- Local to the module: FSM state enum.
- Sub-module prv_cause_encoder: combinational priority encoder producing valid, is_intr, is_ret, code, tval_sel, parametrised on NUM_EXTENSIONS and RMGMT_CAUSE_BASE.

Test Plan:
- illegal_insn=1, epc=0x100, mtvec=0x8000_0000, pipe_clear at +2, insert_ack at once -> csr_commit with mcause=2, mepc_wr=0x100, mtval_wr=0; then insert_pc with priv_pc=0x8000_0000; busy falls after the ack.
- intr=1 with intr_cause=7, plus mal_l=1, mtvec=0x8000_0001 -> mcause=0x8000_0007, priv_pc=0x8000_001C; the exception is ignored.
- ex_rmgmt=4'b1010 -> mcause=25; fault_s+mal_s together -> mcause=6, mtval_wr=badaddr.
- ret=1 with mepc_rd=0x2003 -> is_ret=1 on the commit, priv_pc=0x2000; ret+env_m together -> mcause=11, no is_ret.
- insert_ack held low for 5 cycles, with fault_l pulsed during WAIT_CLEAR -> insert_pc and priv_pc stable for 5 cycles, single csr_commit, no second capture.
- nRST asserted during WAIT_CLEAR -> all outputs 0 immediately, no csr_commit; under PRV_TVAL_INSN_EN, illegal_insn with insn_bits=0xFFFF_FFFF -> mtval_wr=0xFFFF_FFFF.
